char_entry_buffer: RTL

CHAR_ENTRY_BUFFER -- requirements
Module: char_entry_buffer

---
 rtl/char_entry_buffer.sv | 139 +++++++++++++
 1 files changed

// File: rtl/char_entry_buffer.sv
// Eight-slot character entry buffer driven by three debounced push-buttons.
// Buttons are synchronized, debounced, edge-detected, then applied as clr > del > add.
module char_entry_buffer #(
    parameter int unsigned DEBOUNCE_CYCLES = 2000000,
    parameter int unsigned MAX_CODE        = 35
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [5:0] sw_i,
    input  logic       btn_add_i,
    input  logic       btn_del_i,
    input  logic       btn_clr_i,
    output logic [5:0] r0_o,
    output logic [5:0] r1_o,
    output logic [5:0] r2_o,
    output logic [5:0] r3_o,
    output logic [5:0] r4_o,
    output logic [5:0] r5_o,
    output logic [5:0] r6_o,
    output logic [5:0] r7_o,
    output logic [3:0] count_o,
    output logic       full_o,
    output logic       err_o
);

    localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

    // Bit 0 = add, bit 1 = del, bit 2 = clr.
    logic [2:0]      btn_raw;
    logic [2:0]      sync1_q, sync2_q;
    logic [2:0]      level_q, level_d, level_dly_q;
    logic [2:0]      evt_q;
    logic [CntW-1:0] cnt_q [3];
    logic [CntW-1:0] cnt_d [3];

    assign btn_raw = {btn_clr_i, btn_del_i, btn_add_i};

    // The level flips on the cycle the counter would reach DEBOUNCE_CYCLES.
    always_comb begin
        for (int i = 0; i < 3; i++) begin
            cnt_d[i]   = '0;
            level_d[i] = level_q[i];
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == CntMax) begin
                    level_d[i] = ~level_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntW'(1);
                end
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            level_q     <= '0;
            level_dly_q <= '0;
            evt_q       <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            sync1_q     <= btn_raw;
            sync2_q     <= sync1_q;
            level_q     <= level_d;
            level_dly_q <= level_q;
            evt_q       <= level_q & ~level_dly_q;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    logic [5:0] slot_q [8];
    logic [5:0] slot_d [8];
    logic [3:0] count_q, count_d;
    logic       err_q, err_d;
    logic [2:0] add_idx, del_idx;
    logic       code_bad;

    assign add_idx  = count_q[2:0];
    assign del_idx  = 3'(count_q - 4'd1);
    assign code_bad = (32'(sw_i) > MAX_CODE);

    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        err_d   = 1'b0;
        if (evt_q[2]) begin
            for (int i = 0; i < 8; i++) begin
                slot_d[i] = '0;
            end
            count_d = '0;
        end else if (evt_q[1]) begin
            if (count_q == 4'd0) begin
                err_d = 1'b1;
            end else begin
                slot_d[del_idx] = '0;
                count_d         = count_q - 4'd1;
            end
        end else if (evt_q[0]) begin
            if (count_q == 4'd8 || code_bad) begin
                err_d = 1'b1;
            end else begin
                slot_d[add_idx] = sw_i;
                count_d         = count_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < 8; i++) begin
                slot_q[i] <= '0;
            end
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign r0_o    = slot_q[0];
    assign r1_o    = slot_q[1];
    assign r2_o    = slot_q[2];
    assign r3_o    = slot_q[3];
    assign r4_o    = slot_q[4];
    assign r5_o    = slot_q[5];
    assign r6_o    = slot_q[6];
    assign r7_o    = slot_q[7];
    assign count_o = count_q;
    assign full_o  = (count_q == 4'd8);
    assign err_o   = err_q;

endmodule
